// File: rtl/sr_latch_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sr_latch_driver
//  Description : Sequences a write into an external gated SR latch. A request
//                is set up on S/R, strobed with E for PULSE_W cycles, and the
//                latch Q/Qn feedback is then watched for up to TIMEOUT cycles.
//                The outcome is reported as a one-cycle done or err pulse, and
//                a saturating counter keeps track of how many writes timed out.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_latch_driver #(
    parameter int PULSE_W = 2,   // cycles E is held high (1..15)
    parameter int TIMEOUT = 8    // CHECK cycles allowed for feedback (1..255)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_val,
    output logic       req_ready,
    output logic       S,
    output logic       R,
    output logic       E,
    input  logic       Q_fb,
    input  logic       Qn_fb,
    output logic       done,
    output logic       err,
    output logic       busy,
    output logic [7:0] err_cnt
);

    // State encoding
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_PULSE = 3'd2;
    localparam logic [2:0] c_ST_CHECK = 3'd3;
    localparam logic [2:0] c_ST_RESP  = 3'd4;

    // Terminal counts: the counter starts at 0 on entry to a state, so the
    // last cycle of an N-cycle window is reached when it equals N-1.
    localparam logic [7:0] c_PULSE_LAST   = 8'(PULSE_W - 1);
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] c_ERR_MAX      = 8'hFF;

    logic [2:0] r_state;
    logic       r_tgt;
    logic [7:0] r_cnt;

    logic       w_match;
    logic       w_accept;

    // Feedback agrees with the target only when Q and Qn are complementary
    // and Q equals the target; Q==Qn therefore never counts as a match.
    assign w_match  = (Q_fb == r_tgt) && (Qn_fb == ~r_tgt);

    // A request is taken only from IDLE, where req_ready is registered high.
    assign w_accept = (r_state == c_ST_IDLE) && req_valid && req_ready;

    // Single FSM process: next state, internal counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_tgt     <= 1'b0;
            r_cnt     <= 8'd0;
            S         <= 1'b0;
            R         <= 1'b0;
            E         <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            err_cnt   <= 8'd0;
            req_ready <= 1'b1;
        end else begin
            // done/err are single-cycle pulses; only the CHECK exit raises them.
            done <= 1'b0;
            err  <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        // Present the data one cycle ahead of the enable.
                        r_state   <= c_ST_SETUP;
                        r_tgt     <= req_val;
                        r_cnt     <= 8'd0;
                        S         <= req_val;
                        R         <= ~req_val;
                        E         <= 1'b0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        S         <= 1'b0;
                        R         <= 1'b0;
                        E         <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                c_ST_SETUP: begin
                    // Data has been stable for a cycle; open the latch gate.
                    r_state <= c_ST_PULSE;
                    r_cnt   <= 8'd0;
                    S       <= r_tgt;
                    R       <= ~r_tgt;
                    E       <= 1'b1;
                end

                c_ST_PULSE: begin
                    if (r_cnt == c_PULSE_LAST) begin
                        // Close the gate and release the drives together so
                        // the latch holds its new value on its own.
                        r_state <= c_ST_CHECK;
                        r_cnt   <= 8'd0;
                        S       <= 1'b0;
                        R       <= 1'b0;
                        E       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                c_ST_CHECK: begin
                    if (w_match) begin
                        r_state <= c_ST_RESP;
                        r_cnt   <= 8'd0;
                        done    <= 1'b1;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_state <= c_ST_RESP;
                        r_cnt   <= 8'd0;
                        err     <= 1'b1;
                        if (err_cnt != c_ERR_MAX) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                c_ST_RESP: begin
                    // Return to IDLE; a held req_valid is taken at the next edge.
                    r_state   <= c_ST_IDLE;
                    r_cnt     <= 8'd0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end

                default: begin
                    // Unreachable encodings recover to a quiet IDLE.
                    r_state   <= c_ST_IDLE;
                    r_cnt     <= 8'd0;
                    S         <= 1'b0;
                    R         <= 1'b0;
                    E         <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_latch_driver
//  Description : Self-checking bench for sr_latch_driver with a behavioural
//                gated SR latch, a response scoreboard and per-cycle rule checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_latch_driver;

    localparam int c_PULSE_W = 2;
    localparam int c_TIMEOUT = 8;
    localparam int c_LAT_OK  = c_PULSE_W + 3;
    localparam int c_LAT_TO  = c_PULSE_W + 2 + c_TIMEOUT;
    localparam int c_K_DONE  = 1;
    localparam int c_K_ERR   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_val = 1'b0;
    logic       req_ready, S, R, E, done, err, busy;
    logic       Q_fb, Qn_fb;
    logic [7:0] err_cnt;

    // Latch model: 0 = healthy, 1 = Q stuck at 1, 2 = Q and Qn both 1
    int         fb_mode = 0;
    logic       q_lat = 1'b0;

    typedef struct {
        int         kind;
        logic [7:0] cnt;
    } resp_t;
    resp_t      exp_q[$];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         e_run   = 0;
    logic [7:0] exp_err_cnt = 8'd0;

    sr_latch_driver #(.PULSE_W(c_PULSE_W), .TIMEOUT(c_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_val   (req_val),
        .req_ready (req_ready),
        .S         (S),
        .R         (R),
        .E         (E),
        .Q_fb      (Q_fb),
        .Qn_fb     (Qn_fb),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Gated SR latch: transparent while E is high at a clock edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (E) begin
            if (S && !R)      q_lat <= 1'b1;
            else if (R && !S) q_lat <= 1'b0;
        end
    end

    assign Q_fb  = (fb_mode == 0) ? q_lat  : 1'b1;
    assign Qn_fb = (fb_mode == 0) ? ~q_lat : (fb_mode == 2);

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response pulse appears
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected: got done=%0b err=%0b expected none", done, err);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                if ((done ? c_K_DONE : c_K_ERR) != e.kind || err_cnt != e.cnt) begin
                    n_fail++;
                    $display("FAIL resp: got done=%0b err=%0b err_cnt=%0d expected kind=%0d err_cnt=%0d",
                             done, err, err_cnt, e.kind, e.cnt);
                end
            end
        end
    end

    // Per-cycle rules: S/R exclusive, done/err exclusive, E only inside a busy
    // pulse window of at most PULSE_W cycles with complementary drives.
    always @(negedge clk) begin
        if (E) e_run = e_run + 1;
        else   e_run = 0;
        if ((S && R) || (done && err) || (E && (!busy || S == R || e_run > c_PULSE_W))) begin
            n_fail++;
            $display("FAIL cycle_rules: S=%0b R=%0b E=%0b busy=%0b done=%0b err=%0b erun=%0d",
                     S, R, E, busy, done, err, e_run);
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready_timeout", int'(req_ready), 1);
    endtask

    function automatic void push_exp(input int kind);
        resp_t e;
        if (kind == c_K_ERR && exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
        e.kind = kind;
        e.cnt  = exp_err_cnt;
        exp_q.push_back(e);
    endfunction

    // Issue one request and measure edges from the accept edge to the response
    task automatic run_req(input logic val, input int kind, input int exp_lat, input string nm);
        int lat;
        wait_ready();
        push_exp(kind);
        req_valid = 1'b1;
        req_val   = val;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!(done || err) && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(nm, lat, exp_lat);
    endtask

    initial begin
        int t_prev;
        int t_now;

        // Reset with req_valid asserted: the request must be ignored
        req_valid = 1'b1;
        req_val   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_S", int'(S), 0);
        check("rst_R", int'(R), 0);
        check("rst_E", int'(E), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done_err", int'(done | err), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1 check("ready_after_rst", int'(req_ready), 1);
        check("idle_after_rst", int'(busy), 0);

        // Set case with per-edge check of the drive waveform
        wait_ready();
        push_exp(c_K_DONE);
        req_valid = 1'b1;
        req_val   = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) req_valid = 1'b0;
            check($sformatf("set_S_e%0d", k), int'(S), (k <= 3) ? 1 : 0);
            check($sformatf("set_R_e%0d", k), int'(R), 0);
            check($sformatf("set_E_e%0d", k), int'(E), (k == 2 || k == 3) ? 1 : 0);
            check($sformatf("set_done_e%0d", k), int'(done), (k == 5) ? 1 : 0);
            check($sformatf("set_ready_e%0d", k), int'(req_ready), (k == 6) ? 1 : 0);
        end
        check("set_latch_q", int'(q_lat), 1);

        // Target equals current latch state: full sequence still runs
        run_req(1'b1, c_K_DONE, c_LAT_OK, "same_value_latency");
        // Reset the latch to 0
        run_req(1'b0, c_K_DONE, c_LAT_OK, "clear_latency");
        check("clear_latch_q", int'(q_lat), 0);

        // Timeout: target 0 while Q is stuck at 1
        fb_mode = 1;
        run_req(1'b0, c_K_ERR, c_LAT_TO, "timeout_latency");
        check("timeout_err_cnt", int'(err_cnt), 1);

        // Invalid feedback: Q == Qn never matches
        fb_mode = 2;
        run_req(1'b1, c_K_ERR, c_LAT_TO, "invalid_fb_latency");
        check("invalid_err_cnt", int'(err_cnt), 2);
        fb_mode = 0;

        // Reset during the second PULSE cycle
        wait_ready();
        req_valid = 1'b1;
        req_val   = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("mid_pulse_E_before_rst", int'(E), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_E", int'(E), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_err_cnt", int'(err_cnt), 0);
        exp_err_cnt = 8'd0;
        rst = 1'b0;
        @(posedge clk);
        #1 check("mid_rst_ready", int'(req_ready), 1);
        repeat (c_TIMEOUT + 4) @(posedge clk);

        // Back-to-back with req_valid held and alternating targets
        wait_ready();
        for (int k = 0; k < 4; k++) push_exp(c_K_DONE);
        req_valid = 1'b1;
        req_val   = 1'b0;
        t_prev    = 0;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            @(posedge clk);
            #1;
            while (!done && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            t_now = cyc;
            check($sformatf("b2b_done_%0d", k), int'(done), 1);
            check($sformatf("b2b_latch_%0d", k), int'(q_lat), k % 2);
            if (k > 0) check($sformatf("b2b_spacing_%0d", k), t_now - t_prev, c_PULSE_W + 4);
            t_prev = t_now;
            req_val = ~req_val;
            if (k == 3) req_valid = 1'b0;
        end

        // Saturation of the error counter
        fb_mode = 1;
        for (int k = 0; k < 260; k++) begin
            run_req(1'b0, c_K_ERR, c_LAT_TO, "sat_latency");
        end
        @(negedge clk);
        check("sat_err_cnt", int'(err_cnt), 255);
        fb_mode = 0;

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
